mips_multicycle_core: RTL and testbench
=======================================

Name: mips_multicycle_core

Overview:
Parametrised multi-cycle MIPS32 core. Datapath and main-control FSM are in one block. A single unified instruction/data memory port carries a ready handshake, so the core tolerates wait states. It replaces the single-cycle datapath/controller pair. The core shares one ALU and one memory port across cycles.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, width of mem_addr; the low ADDR_W bits of the address are driven
TRAP_ON_ILLEGAL, 1, 1 = illegal opcode/funct enters TRAP; 0 = treated as NOP and retired

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
mem_req  out  1  memory access request, held until mem_ready
mem_we  out  1  1 = write, valid while mem_req
mem_addr  out  ADDR_W  byte address, word aligned
mem_wdata  out  32  store data, valid while mem_req && mem_we
mem_rdata  in  32  read data, sampled in the cycle mem_req && mem_ready
mem_ready  in  1  access completes this cycle
pc  out  32  current PC
halted  out  1  core is in TRAP
retire  out  1  one-cycle pulse, an instruction completed
state_dbg  out  4  current FSM state encoding

Behaviour:
- Reset: clk, rst are synchronous and active-high. On rst at a clock edge:
  - pc=RESET_PC; state=FETCH; all 32 registers=0; IR, MDR, A, B, ALUOut=0.
  - mem_req=0 in the cycle after the edge; halted=0; retire=0.
  - Reset mid-access abandons the access; the memory must tolerate a dropped request.
- Register file: 32x32. r0 reads 0 and writes to r0 are discarded. Write port is active only in writeback states.
- Supported instructions: R-type add, sub, and, or, slt, sll, srl (shamt=IR[10:6]); lw; sw; beq; bne; addi; j.
- States and transitions:
  - FETCH: mem_req=1, we=0, addr=pc. Stay until mem_ready. On ready: IR<=rdata, pc<=pc+4 → DECODE.
  - DECODE: A<=rf[rs], B<=rf[rt], ALUOut<=pc+(sext(imm)<<2). Next by opcode; illegal → TRAP, or FETCH+retire if TRAP_ON_ILLEGAL=0.
  - MEMADR: ALUOut<=A+sext(imm) → MEMRD for lw, MEMWR for sw.
  - MEMRD: mem_req=1, we=0, addr=ALUOut; wait on ready; MDR<=rdata → MEMWB.
  - MEMWB: rf[rt]<=MDR, retire → FETCH.
  - MEMWR: mem_req=1, we=1, wdata=B; wait on ready; retire → FETCH.
  - EXEC: ALUOut<=A op B per funct → ALUWB.
  - ALUWB: rf[rd]<=ALUOut, retire → FETCH.
  - ADDIEX: ALUOut<=A+sext(imm) → ADDIWB.
  - ADDIWB: rf[rt]<=ALUOut, retire → FETCH.
  - BRANCH: the comparison uses the ALU SUB zero flag. Taken (beq zero / bne !zero): pc<=ALUOut. Retire → FETCH.
  - JUMP: pc<={pc[31:28],IR[25:0],2'b00}, retire → FETCH.
  - TRAP: halted=1, mem_req=0, no state change until rst.
- Latency with zero wait states: lw 5, sw 4, R-type 4, addi 4, beq/bne 3, j 3 cycles. Each memory wait cycle adds exactly 1.
- mem_req, mem_we, mem_addr and mem_wdata are stable while waiting. mem_req falls in the cycle after mem_ready.
- Arithmetic: 32-bit wrap, no overflow exception. slt is signed. sll/srl shift B by shamt; srl is logical.
- Address bits [1:0] are not checked; unaligned addresses pass through unchanged.
- retire pulses exactly once per completed instruction and never in TRAP.

Decomposition:
- Shared package mc_pkg holds:
  - opcodes: RTYPE 000000, LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000, J 000010.
  - funct codes: add 100000, sub 100010, and 100100, or 100101, slt 101010, sll 000000, srl 000010.
  - ALU control codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SLL 1000, SRL 1001.
  - FSM state encodings 0..12.
- Sub-module mc_controller holds the FSM and the opcode/funct decode and drives all datapath enables. The datapath, regfile and ALU stay in the top module.

Test Plan:
- Reset, RESET_PC=0x100, memory with zero wait → first mem_addr=0x100; pc=0x104 after FETCH; state_dbg sequence FETCH→DECODE.
- addi r1,r0,5; addi r2,r0,7; add r3,r1,r2; sw r3,0x40(r0) → write at 0x40 with wdata=12; retire count 4 in 16 cycles.
- lw r4,0x40(r0), memory inserting 3 wait cycles per access → r4=12; instruction takes 5+6=11 cycles; mem_addr held stable during waits.
- beq r1,r1,-1 taken → pc returns to the branch address. bne r1,r1 not taken → pc+4. Each takes 3 cycles.
- j 0x0000040, slt r5,r1,r2 with r1=-1, r2=7 → pc=0x100, r5=1. add r0,r1,r2 leaves r0=0.
- Illegal opcode 111111: TRAP_ON_ILLEGAL=1 → halted=1, mem_req=0. rst mid-MEMRD → mem_req=0 next cycle, pc=RESET_PC, halted=0.

Source files
------------

// File: rtl/mc_pkg.sv
// mc_pkg: shared opcodes, funct codes, ALU controls, FSM states and mux selects for the multi-cycle MIPS core
package mc_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_SLL = 6'b000000;
    localparam logic [5:0] FN_SRL = 6'b000010;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_SLL = 4'b1000,
        ALU_SRL = 4'b1001
    } alu_op_e;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR, S_EXEC,
        S_ALUWB, S_ADDIEX, S_ADDIWB, S_BRANCH, S_JUMP, S_TRAP
    } state_e;

    typedef enum logic [1:0] {B_REG, B_FOUR, B_IMM, B_BRANCH} alu_b_e;

    typedef enum logic [1:0] {PC_ALU, PC_ALUOUT, PC_JUMP} pc_src_e;

    function automatic alu_op_e funct_alu(input logic [5:0] f);
        return (f == FN_SUB) ? ALU_SUB :
               (f == FN_AND) ? ALU_AND :
               (f == FN_OR)  ? ALU_OR  :
               (f == FN_SLT) ? ALU_SLT :
               (f == FN_SLL) ? ALU_SLL :
               (f == FN_SRL) ? ALU_SRL : ALU_ADD;
    endfunction

    function automatic logic funct_ok(input logic [5:0] f);
        return f inside {FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_SRL};
    endfunction

endpackage

// File: rtl/mc_controller.sv
// mc_controller: main FSM and opcode/funct decode driving every datapath enable and mux select.
// Ports: op_i/funct_i from IR, mem_ready_i handshake, zero_i from ALU; outputs are
// memory request/write/address-select, register enables, ALU operand/op selects,
// PC update controls, retire/halted pulses and the raw state encoding.
module mc_controller
    import mc_pkg::*;
#(
    parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    input  logic       mem_ready_i,
    input  logic       zero_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       addr_alu_o,
    output logic       ir_we_o,
    output logic       pc_we_o,
    output logic [1:0] pc_src_o,
    output logic       ab_we_o,
    output logic       alu_a_pc_o,
    output logic [1:0] alu_b_sel_o,
    output logic [3:0] alu_ctl_o,
    output logic       aluout_we_o,
    output logic       mdr_we_o,
    output logic       rf_we_o,
    output logic       rf_dst_rt_o,
    output logic       rf_mdr_o,
    output logic       retire_o,
    output logic       halted_o,
    output logic [3:0] state_o
);

    state_e state_q, state_d, dec_next;
    logic   go_q, rdy, legal;

    // go_q holds off the first fetch request for one cycle after reset
    assign rdy   = mem_ready_i & go_q;
    assign legal = (op_i == OP_RTYPE) ? funct_ok(funct_i)
                 : op_i inside {OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
    assign dec_next = !legal ? (TRAP_ON_ILLEGAL ? S_TRAP : S_FETCH) :
                      (op_i == OP_RTYPE) ? S_EXEC :
                      (op_i == OP_LW || op_i == OP_SW) ? S_MEMADR :
                      (op_i == OP_ADDI) ? S_ADDIEX :
                      (op_i == OP_J) ? S_JUMP : S_BRANCH;
    assign state_o = state_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            go_q    <= 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        addr_alu_o  = 1'b0;
        ir_we_o     = 1'b0;
        pc_we_o     = 1'b0;
        pc_src_o    = PC_ALU;
        ab_we_o     = 1'b0;
        alu_a_pc_o  = 1'b0;
        alu_b_sel_o = B_REG;
        alu_ctl_o   = ALU_ADD;
        aluout_we_o = 1'b0;
        mdr_we_o    = 1'b0;
        rf_we_o     = 1'b0;
        rf_dst_rt_o = 1'b0;
        rf_mdr_o    = 1'b0;
        retire_o    = 1'b0;
        halted_o    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req_o   = go_q;
                alu_a_pc_o  = 1'b1;
                alu_b_sel_o = B_FOUR;
                ir_we_o     = rdy;
                pc_we_o     = rdy;
                state_d     = rdy ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ab_we_o     = 1'b1;
                alu_a_pc_o  = 1'b1;
                alu_b_sel_o = B_BRANCH;
                aluout_we_o = 1'b1;
                retire_o    = !legal && !TRAP_ON_ILLEGAL;
                state_d     = dec_next;
            end
            S_MEMADR: begin
                alu_b_sel_o = B_IMM;
                aluout_we_o = 1'b1;
                state_d     = (op_i == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                mem_req_o  = 1'b1;
                addr_alu_o = 1'b1;
                mdr_we_o   = mem_ready_i;
                state_d    = mem_ready_i ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                rf_we_o     = 1'b1;
                rf_dst_rt_o = 1'b1;
                rf_mdr_o    = 1'b1;
                retire_o    = 1'b1;
                state_d     = S_FETCH;
            end
            S_MEMWR: begin
                mem_req_o  = 1'b1;
                mem_we_o   = 1'b1;
                addr_alu_o = 1'b1;
                retire_o   = mem_ready_i;
                state_d    = mem_ready_i ? S_FETCH : S_MEMWR;
            end
            S_EXEC: begin
                alu_ctl_o   = funct_alu(funct_i);
                aluout_we_o = 1'b1;
                state_d     = S_ALUWB;
            end
            S_ALUWB: begin
                rf_we_o  = 1'b1;
                retire_o = 1'b1;
                state_d  = S_FETCH;
            end
            S_ADDIEX: begin
                alu_b_sel_o = B_IMM;
                aluout_we_o = 1'b1;
                state_d     = S_ADDIWB;
            end
            S_ADDIWB: begin
                rf_we_o     = 1'b1;
                rf_dst_rt_o = 1'b1;
                retire_o    = 1'b1;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                alu_ctl_o = ALU_SUB;
                pc_we_o   = zero_i ^ (op_i == OP_BNE);
                pc_src_o  = PC_ALUOUT;
                retire_o  = 1'b1;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                pc_we_o  = 1'b1;
                pc_src_o = PC_JUMP;
                retire_o = 1'b1;
                state_d  = S_FETCH;
            end
            S_TRAP: halted_o = 1'b1;
            default: state_d = S_FETCH;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multi-cycle MIPS32 datapath (PC, IR, MDR, A/B, ALUOut, regfile, shared ALU).
// Ports: clk/rst; unified memory port mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o with
// mem_rdata_i/mem_ready_i handshake; debug outputs pc_o, halted_o, retire_o, state_dbg_o.
module mips_multicycle_core
    import mc_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter int          ADDR_W          = 32,
    parameter bit          TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [31:0]       mem_wdata_o,
    input  logic [31:0]       mem_rdata_i,
    input  logic              mem_ready_i,
    output logic [31:0]       pc_o,
    output logic              halted_o,
    output logic              retire_o,
    output logic [3:0]        state_dbg_o
);

    logic [31:0] pc_q, ir_q, mdr_q, a_q, b_q, aluout_q;
    logic [31:0] rf_q [32];
    logic [31:0] imm_sx, alu_a, alu_b, alu_y, pc_d, wd;
    logic [4:0]  rs, rt, rd, shamt, wa;
    logic [3:0]  alu_ctl;
    logic [1:0]  alu_b_sel, pc_src;
    logic        addr_alu, ir_we, pc_we, ab_we, alu_a_pc, aluout_we, mdr_we;
    logic        rf_we, rf_dst_rt, rf_mdr, zero;

    mc_controller #(.TRAP_ON_ILLEGAL(TRAP_ON_ILLEGAL)) u_ctrl (
        .clk        (clk),
        .rst        (rst),
        .op_i       (ir_q[31:26]),
        .funct_i    (ir_q[5:0]),
        .mem_ready_i(mem_ready_i),
        .zero_i     (zero),
        .mem_req_o  (mem_req_o),
        .mem_we_o   (mem_we_o),
        .addr_alu_o (addr_alu),
        .ir_we_o    (ir_we),
        .pc_we_o    (pc_we),
        .pc_src_o   (pc_src),
        .ab_we_o    (ab_we),
        .alu_a_pc_o (alu_a_pc),
        .alu_b_sel_o(alu_b_sel),
        .alu_ctl_o  (alu_ctl),
        .aluout_we_o(aluout_we),
        .mdr_we_o   (mdr_we),
        .rf_we_o    (rf_we),
        .rf_dst_rt_o(rf_dst_rt),
        .rf_mdr_o   (rf_mdr),
        .retire_o   (retire_o),
        .halted_o   (halted_o),
        .state_o    (state_dbg_o)
    );

    assign rs     = ir_q[25:21];
    assign rt     = ir_q[20:16];
    assign rd     = ir_q[15:11];
    assign shamt  = ir_q[10:6];
    assign imm_sx = {{16{ir_q[15]}}, ir_q[15:0]};

    // one ALU serves pc+4, branch target, address/immediate add, R-type ops and branch compare
    assign alu_a = alu_a_pc ? pc_q : a_q;
    assign alu_b = (alu_b_sel == B_REG)  ? b_q :
                   (alu_b_sel == B_FOUR) ? 32'd4 :
                   (alu_b_sel == B_IMM)  ? imm_sx : (imm_sx << 2);
    assign alu_y = (alu_ctl == ALU_AND) ? (alu_a & alu_b) :
                   (alu_ctl == ALU_OR)  ? (alu_a | alu_b) :
                   (alu_ctl == ALU_SUB) ? (alu_a - alu_b) :
                   (alu_ctl == ALU_SLT) ? {31'd0, $signed(alu_a) < $signed(alu_b)} :
                   (alu_ctl == ALU_SLL) ? (alu_b << shamt) :
                   (alu_ctl == ALU_SRL) ? (alu_b >> shamt) : (alu_a + alu_b);
    assign zero  = (alu_y == 32'd0);

    assign pc_d = (pc_src == PC_ALU)    ? alu_y :
                  (pc_src == PC_ALUOUT) ? aluout_q : {pc_q[31:28], ir_q[25:0], 2'b00};
    assign wa   = rf_dst_rt ? rt : rd;
    assign wd   = rf_mdr ? mdr_q : aluout_q;

    assign mem_addr_o  = addr_alu ? aluout_q[ADDR_W-1:0] : pc_q[ADDR_W-1:0];
    assign mem_wdata_o = b_q;
    assign pc_o        = pc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            mdr_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            aluout_q <= '0;
            for (int i = 0; i < 32; i++) rf_q[i] <= '0;
        end else begin
            if (pc_we) pc_q <= pc_d;
            if (ir_we) ir_q <= mem_rdata_i;
            if (mdr_we) mdr_q <= mem_rdata_i;
            if (ab_we) begin
                a_q <= rf_q[rs];
                b_q <= rf_q[rt];
            end
            if (aluout_we) aluout_q <= alu_y;
            if (rf_we && wa != 5'd0) rf_q[wa] <= wd;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: program-driven scoreboard bench for the multi-cycle MIPS core
module tb_mips_multicycle_core;

    localparam logic [31:0] RPC = 32'h100;

    logic        clk = 1'b0, rst = 1'b1;
    logic        mem_req, mem_we, mem_ready = 1'b0, halted, retire;
    logic [31:0] mem_addr, mem_wdata, mem_rdata = '0, pc;
    logic [3:0]  state_dbg;

    mips_multicycle_core #(.RESET_PC(RPC), .ADDR_W(32), .TRAP_ON_ILLEGAL(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .mem_req_o  (mem_req),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata),
        .mem_ready_i(mem_ready),
        .pc_o       (pc),
        .halted_o   (halted),
        .retire_o   (retire),
        .state_dbg_o(state_dbg)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [256];
    int          total = 0, bad = 0, waits = 0, wcnt = 0, cyc = 0, prev_ret = 0, n_ret = 0;
    bit          based = 0, chk_dec = 0;
    logic [31:0] last_fetch, h_addr, h_wdata;
    logic [63:0] w;
    logic [31:0] fq [$];
    logic [31:0] lq [$];
    logic [63:0] wq [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] r_op(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sh,
                                         input logic [5:0] fn);
        return {6'd0, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_op(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    task automatic put(input logic [31:0] a, input logic [31:0] d);
        mem[a[9:2]] = d;
    endtask

    task automatic wait_ret(input int n, input int budget);
        int k = 0;
        while (n_ret < n && k < budget) begin
            @(negedge clk);
            #3;
            k++;
        end
        if (n_ret < n) chk("retire_timeout", n_ret, n);
    endtask

    // memory responder (decides ready at negedge) and output monitor (#2 later)
    initial forever begin
        @(negedge clk);
        if (mem_req) begin
            if (wcnt == 0) begin
                h_addr  = mem_addr;
                h_wdata = mem_wdata;
            end else begin
                chk("addr_hold", mem_addr, h_addr);
                if (mem_we) chk("wdata_hold", mem_wdata, h_wdata);
            end
            mem_ready = (wcnt == waits);
            mem_rdata = mem[mem_addr[9:2]];
            wcnt      = mem_ready ? 0 : wcnt + 1;
            if (mem_ready && mem_we) mem[mem_addr[9:2]] = mem_wdata;
        end else begin
            mem_ready = 1'b0;
            wcnt      = 0;
        end
        #2;
        if (rst) begin
            based   = 0;
            chk_dec = 0;
        end else begin
            cyc++;
            if (chk_dec) begin
                chk("pc_plus4", pc, last_fetch + 32'd4);
                chk("decode_state", {28'd0, state_dbg}, 32'd1);
                chk_dec = 0;
            end
            if (mem_req && !based) begin
                prev_ret = cyc - 1;
                based    = 1;
            end
            if (mem_req && mem_ready && !mem_we && state_dbg == 4'd0) begin
                last_fetch = mem_addr;
                chk("fetch_addr", mem_addr, fq.size() != 0 ? fq.pop_front() : 32'hDEAD_BEEF);
                chk_dec = 1;
            end
            if (mem_req && mem_ready && mem_we) begin
                w = wq.size() != 0 ? wq.pop_front() : '1;
                chk("store_addr", mem_addr, w[63:32]);
                chk("store_data", mem_wdata, w[31:0]);
            end
            if (retire) begin
                chk("latency", cyc - prev_ret, lq.size() != 0 ? lq.pop_front() : 32'hDEAD_BEEF);
                prev_ret = cyc;
                n_ret++;
            end
        end
    end

    initial begin
        int lat [24] = '{4, 4, 4, 4, 11, 4, 3, 3, 4, 3, 4, 4, 4, 4,
                         4, 4, 4, 4, 4, 4, 4, 4, 4, 4};
        int k;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        put(32'h100, i_op(6'h08, 5'd0, 5'd1, 16'd5));
        put(32'h104, i_op(6'h08, 5'd0, 5'd2, 16'd7));
        put(32'h108, r_op(5'd1, 5'd2, 5'd3, 5'd0, 6'h20));
        put(32'h10C, i_op(6'h2B, 5'd0, 5'd3, 16'h40));
        put(32'h110, i_op(6'h23, 5'd0, 5'd4, 16'h40));
        put(32'h114, i_op(6'h2B, 5'd0, 5'd4, 16'h44));
        put(32'h118, i_op(6'h04, 5'd1, 5'd1, 16'hFFFF));
        put(32'h11C, i_op(6'h08, 5'd0, 5'd1, 16'hFFFF));
        put(32'h120, {6'h02, 26'h40});
        foreach (lat[i]) lq.push_back(32'(lat[i]));
        for (int a = 'h100; a <= 'h118; a += 4) fq.push_back(32'(a));
        fq.push_back(32'h118);
        fq.push_back(32'h11C);
        fq.push_back(32'h120);
        for (int a = 'h100; a <= 'h138; a += 4) fq.push_back(32'(a));
        wq.push_back({32'h40, 32'd12});
        wq.push_back({32'h44, 32'd12});
        wq.push_back({32'h48, 32'd1});
        wq.push_back({32'h4C, 32'd0});
        wq.push_back({32'h50, 32'd8});
        wq.push_back({32'h54, 32'd4});
        wq.push_back({32'h58, 32'd15});
        wq.push_back({32'h5C, 32'h70});
        wq.push_back({32'h60, 32'hF});

        repeat (2) @(negedge clk);
        #3;
        chk("rst_req", {31'd0, mem_req}, 32'd0);
        chk("rst_pc", pc, RPC);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("rst_retire", {31'd0, retire}, 32'd0);
        chk("rst_state", {28'd0, state_dbg}, 32'd0);
        rst = 1'b0;

        wait_ret(4, 200);
        waits = 3;
        wait_ret(5, 200);
        waits = 0;
        put(32'h100, r_op(5'd1, 5'd2, 5'd5, 5'd0, 6'h2A));
        put(32'h104, r_op(5'd1, 5'd2, 5'd0, 5'd0, 6'h20));
        put(32'h108, i_op(6'h2B, 5'd0, 5'd5, 16'h48));
        put(32'h10C, i_op(6'h2B, 5'd0, 5'd0, 16'h4C));
        wait_ret(7, 200);
        put(32'h118, i_op(6'h05, 5'd1, 5'd1, 16'hFFFF));
        wait_ret(10, 200);
        put(32'h110, r_op(5'd2, 5'd1, 5'd6, 5'd0, 6'h22));
        put(32'h114, r_op(5'd3, 5'd2, 5'd7, 5'd0, 6'h24));
        put(32'h118, r_op(5'd3, 5'd2, 5'd8, 5'd0, 6'h25));
        put(32'h11C, r_op(5'd0, 5'd2, 5'd9, 5'd4, 6'h00));
        put(32'h120, r_op(5'd0, 5'd1, 5'd10, 5'd28, 6'h02));
        for (int i = 0; i < 5; i++)
            put(32'h124 + 32'(4 * i), i_op(6'h2B, 5'd0, 5'(6 + i), 16'(32'h50 + 4 * i)));
        put(32'h138, 32'hFC00_0000);

        k = 0;
        while (!halted && k < 500) begin
            @(negedge clk);
            #3;
            k++;
        end
        repeat (3) begin
            @(negedge clk);
            #3;
        end
        chk("trap_halted", {31'd0, halted}, 32'd1);
        chk("trap_req", {31'd0, mem_req}, 32'd0);
        chk("trap_state", {28'd0, state_dbg}, 32'd12);
        chk("trap_retire", {31'd0, retire}, 32'd0);
        chk("retire_count", n_ret, 32'd24);
        chk("stores_left", wq.size(), 32'd0);
        chk("fetches_left", fq.size(), 32'd0);

        rst = 1'b1;
        put(32'h100, i_op(6'h23, 5'd0, 5'd4, 16'h40));
        waits = 3;
        fq.push_back(32'h100);
        @(negedge clk);
        #3;
        chk("rst2_req", {31'd0, mem_req}, 32'd0);
        chk("rst2_halted", {31'd0, halted}, 32'd0);
        chk("rst2_pc", pc, RPC);
        rst = 1'b0;
        k = 0;
        while (state_dbg != 4'd3 && k < 100) begin
            @(negedge clk);
            #3;
            k++;
        end
        chk("memrd_state", {28'd0, state_dbg}, 32'd3);
        chk("memrd_req", {31'd0, mem_req}, 32'd1);
        chk("memrd_addr", mem_addr, 32'h40);
        rst = 1'b1;
        @(negedge clk);
        #3;
        chk("abort_req", {31'd0, mem_req}, 32'd0);
        chk("abort_pc", pc, RPC);
        chk("abort_halted", {31'd0, halted}, 32'd0);
        chk("abort_state", {28'd0, state_dbg}, 32'd0);
        chk("abort_fetches_left", fq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
